// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts one word per valid/ready handshake and sends it as
// start bit, data bits LSB first, optional parity bit, then stop bit.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_BITS-1:0]                 tx_data,
  input  logic                                 tx_valid,
  output logic                                 tx_ready,
  output logic                                 tx,
  output logic                                 tx_busy,
  output logic [2:0]                           state_dbg,
  output logic [$clog2(DATA_BITS+1)-1:0]       bit_cnt_dbg,
  output logic [$clog2(CLKS_PER_BIT)-1:0]      baud_cnt_dbg
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_DONE  = BIT_W'(DATA_BITS);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0]  shift;
  logic                  parity_bit;
  logic                  baud_end;

  assign baud_end     = (baud_cnt == BAUD_LAST);
  assign state_dbg    = state;
  assign bit_cnt_dbg  = bit_cnt;
  assign baud_cnt_dbg = baud_cnt;

  // Handshake: a word transfers on a rising edge where tx_valid && tx_ready.
  // tx_ready is high only in IDLE, so inputs are ignored for the whole frame and
  // a producer holding tx_valid high is served at the first IDLE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (tx_valid && tx_ready) begin
            shift      <= tx_data;
            parity_bit <= (^tx_data) ^ PARITY_ODD;
            state      <= S_START;
            tx         <= 1'b0;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
          end
        end

        S_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        S_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              // Counter parks at DATA_BITS until the frame returns to IDLE.
              bit_cnt <= BIT_DONE;
              if (PARITY_EN) begin
                tx    <= parity_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_ONE;
              shift   <= {1'b0, shift[DATA_BITS-1:1]};
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        S_PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        S_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        default: begin
          state    <= S_IDLE;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule
